// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one main-memory port between the I-cache refill engine and the
//   D-cache refill/writeback engine. A granted requester owns the port for a
//   whole line burst of BURST_LEN word beats. The line base is latched at
//   grant, and the beat address auto-increments from that base.
//
//   Optional build macro: MEM_ARB_RR_EN
//     defined   - ties in IDLE go to the requester that was not granted last
//                 (D wins the first tie after reset)
//     undefined - fixed priority, D over I
//
// Ports
//   clk, rst                       clock, async active-high reset
//   i_req/i_addr                   I refill request and miss address
//   i_rdata/i_rvalid/i_done        I refill data, data strobe, end-of-burst pulse
//   d_req/d_we/d_addr/d_wdata      D request (d_we=1 writeback), address, write word
//   d_beat                         beat index that selects d_wdata
//   d_rdata/d_rvalid/d_done        D refill data, data strobe, end-of-burst pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory beat request
//   mem_rdata/mem_ack              memory beat response
//   grant                          debug: 00 idle, 01 I owns port, 10 D owns port
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_req,
  input  logic [ADDR_WIDTH-1:0]        i_addr,
  output logic [DATA_WIDTH-1:0]        i_rdata,
  output logic                         i_rvalid,
  output logic                         i_done,
  input  logic                         d_req,
  input  logic                         d_we,
  input  logic [ADDR_WIDTH-1:0]        d_addr,
  input  logic [DATA_WIDTH-1:0]        d_wdata,
  output logic [$clog2(BURST_LEN)-1:0] d_beat,
  output logic [DATA_WIDTH-1:0]        d_rdata,
  output logic                         d_rvalid,
  output logic                         d_done,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_WIDTH-1:0]        mem_addr,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic [DATA_WIDTH-1:0]        mem_rdata,
  input  logic                         mem_ack,
  output logic [1:0]                   grant
);

  localparam int BW = $clog2(BURST_LEN);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(BURST_LEN*4 - 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t                state;
  logic [BW-1:0]         beat;
  logic [ADDR_WIDTH-1:0] base;
  logic                  weLatched;
  logic                  pickD;
  logic                  busyI, busyD;

`ifdef MEM_ARB_RR_EN
  // 1 when D took the most recent grant; reset value means "I was last",
  // so D wins the first tie.
  logic lastGrantD;
  assign pickD = d_req && (!i_req || !lastGrantD);
`else
  assign pickD = d_req;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      base      <= '0;
      weLatched <= 1'b0;
`ifdef MEM_ARB_RR_EN
      lastGrantD <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // Requests are only looked at here, so a request arriving
          // mid-burst simply waits for the port to come back to IDLE.
          if (pickD) begin
            state     <= BUSY_D;
            base      <= d_addr & ~LINE_MASK;
            weLatched <= d_we;
`ifdef MEM_ARB_RR_EN
            lastGrantD <= 1'b1;
`endif
          end else if (i_req) begin
            state     <= BUSY_I;
            base      <= i_addr & ~LINE_MASK;
            weLatched <= 1'b0;
`ifdef MEM_ARB_RR_EN
            lastGrantD <= 1'b0;
`endif
          end
        end
        default: begin
          if (mem_ack) begin
            if (beat == LAST_BEAT) begin
              state <= IDLE;
              beat  <= '0;
            end else begin
              beat <= beat + BW'(1);
            end
          end
        end
      endcase
    end
  end

  assign busyI = (state == BUSY_I);
  assign busyD = (state == BUSY_D);

  // Request side comes straight from registered state, so there is no
  // combinational path from i_req/d_req to mem_req.
  assign mem_req   = busyI || busyD;
  assign mem_we    = busyD && weLatched;
  assign mem_addr  = mem_req ? base + (ADDR_WIDTH'(beat) << 2) : '0;
  assign mem_wdata = busyD ? d_wdata : '0;
  assign grant     = {busyD, busyI};
  assign d_beat    = busyD ? beat : '0;

  // Response side is a same-cycle pass-through of mem_ack/mem_rdata.
  // Qualifying with the BUSY state drops acks that arrive while idle.
  assign i_rvalid = busyI && mem_ack;
  assign d_rvalid = busyD && mem_ack && !weLatched;
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;
  assign i_done   = busyI && mem_ack && (beat == LAST_BEAT);
  assign d_done   = busyD && mem_ack && (beat == LAST_BEAT);

endmodule
